alu_ctrl_issue: RTL and testbench
=================================

# alu_ctrl_issue

Issue-side counterpart of the datapath ALU. Decodes a 32-bit MIPS instruction into the 4-bit ALU control code and the src2 operand selection, and registers both into the execute stage. A 2-entry skid buffer with valid/ready handshakes on both sides lets the execute stage stall without losing instructions. Sits between the ID and EX stages of the pipelined CPU.

## Interface
- No parameters; widths are fixed by the ISA.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-low reset
- instr_i  in  32  instruction from ID
- valid_i  in  1  instr_i is valid this cycle
- ready_o  out  1  block can accept an instruction this cycle
- flush_i  in  1  discard everything held; branch/jump redirect
- ctrl_o  out  4  ALU control code
- src2_sel_o  out  2  0 = register rt, 1 = sign-ext imm, 2 = zero-ext imm, 3 = shamt
- illegal_o  out  1  opcode/funct not decodable
- instr_o  out  32  registered copy of the issued instruction
- valid_o  out  1  ctrl_o/src2_sel_o/illegal_o/instr_o are valid
- ready_i  in  1  EX stage accepts this cycle

## Operation
- ALU codes: AND 0, OR 1, ADD 2, MUL 3, SUB 6, SLT 7, SRA 10, NOR 12, LUI 14, SLE 15.
- R-type (op 0x00), decoded by funct:
  - 0x20 ADD/0, 0x22 SUB/0, 0x24 AND/0, 0x25 OR/0, 0x27 NOR/0, 0x2A SLT/0, 0x18 MUL/0
  - 0x03 SRA with src2 = 3 (shamt)
  - 0x07 SRA with src2 = 0 (srav)
- I-type, decoded by opcode:
  - 0x08 ADD/1, 0x0A SLT/1, 0x0D OR/2, 0x0F LUI/2
  - 0x04 SUB/0, 0x05 SUB/0
  - 0x06 SLE/0
  - 0x23 ADD/1, 0x2B ADD/1
- Any other opcode or funct decodes to ctrl 0, src2 0, illegal 1. The entry is still issued; the illegal flag travels with it.
- An accept happens when valid_i && ready_o. The decode result is stored with the instruction in the skid buffer.
- An issue happens when valid_o && ready_i.
- Buffer states:
  - EMPTY: valid_o = 0, ready_o = 1.
  - ONE: valid_o = 1, ready_o = 1.
  - FULL: valid_o = 1, ready_o = 0.
- State transitions:
  - EMPTY: accept → ONE.
  - ONE: accept without issue → FULL; issue without accept → EMPTY; both → stays ONE, and the output register loads the new entry.
  - FULL: issue → ONE, and the skid entry moves to the output register.
- Order is strictly FIFO.
- flush_i has priority over everything. The next state is EMPTY, and an accept in the same cycle is dropped.
- While valid_o = 1 and ready_i = 0, the outputs hold stable.

## Timing
- ready_o is driven directly from state (registered). There is no combinational path from ready_i to ready_o.
- Latency is 1 cycle: an instruction accepted at edge N is presented at edge N with valid_o = 1 from that edge, provided the buffer was EMPTY or issuing.
- Sustained throughput is 1 instruction/cycle while ready_i = 1.
- Reset values (asynchronous, when rst_i = 0):
  - state EMPTY
  - valid_o 0, ready_o 1
  - ctrl_o 0, src2_sel_o 0, illegal_o 0, instr_o 0
- If reset asserts in the middle of a transfer, held entries are lost; no partial output.
- Outputs are valid on the first edge after rst_i deasserts.
- Flush asserted at edge N gives valid_o = 0 and ready_o = 1 after edge N.

## Structure
- Package alu_pkg holds:
  - ALU control code constants (4-bit)
  - opcode and funct constants
  - the src2-select enum
- The ALU imports the same package, so the codes are defined in one place.
- Sub-module alu_ctrl_decode is purely combinational: instr → {ctrl, src2_sel, illegal}.
- alu_ctrl_issue holds the skid-buffer FSM and the two entry registers (output + skid).

## Test plan
- Reset then accept 0x00221820 (add $3,$1,$2) with ready_i = 1 → next cycle valid_o = 1, ctrl_o = 2, src2_sel_o = 0, illegal_o = 0.
- Accept 0x3C011234 (lui) → ctrl_o = 14, src2_sel_o = 2. Accept 0x00021903 (sra) → ctrl_o = 10, src2_sel_o = 3.
- Accept 0xFC000000 → ctrl_o = 0, illegal_o = 1, valid_o = 1.
- Hold ready_i = 0 and offer three back-to-back instructions (ADD, SUB, SLT):
  - the first two are accepted, then ready_o = 0 and the third is held upstream;
  - after ready_i rises, ctrl_o issues 2, 6, 7 in order with no loss or duplication.
- With the buffer FULL, assert flush_i together with valid_i → next cycle valid_o = 0, ready_o = 1, and the flushed-cycle instruction is never issued.
- Drop rst_i asynchronously mid-stream (between clock edges) → valid_o = 0 and ctrl_o = 0 immediately; normal operation resumes after deassertion.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared ALU definitions for the issue stage and the datapath ALU.
//           Holds the 4-bit ALU control codes, the MIPS opcode/funct values
//           that the issue stage decodes, the src2 operand-select enum and the
//           skid-buffer entry layout.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] C_ALU_AND = 4'd0;
  localparam logic [3:0] C_ALU_OR  = 4'd1;
  localparam logic [3:0] C_ALU_ADD = 4'd2;
  localparam logic [3:0] C_ALU_MUL = 4'd3;
  localparam logic [3:0] C_ALU_SUB = 4'd6;
  localparam logic [3:0] C_ALU_SLT = 4'd7;
  localparam logic [3:0] C_ALU_SRA = 4'd10;
  localparam logic [3:0] C_ALU_NOR = 4'd12;
  localparam logic [3:0] C_ALU_LUI = 4'd14;
  localparam logic [3:0] C_ALU_SLE = 4'd15;

  // Opcodes (instr[31:26])
  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_SLE   = 6'h06;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_SLTI  = 6'h0A;
  localparam logic [5:0] C_OP_ORI   = 6'h0D;
  localparam logic [5:0] C_OP_LUI   = 6'h0F;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] C_FN_SRA  = 6'h03;
  localparam logic [5:0] C_FN_SRAV = 6'h07;
  localparam logic [5:0] C_FN_MUL  = 6'h18;
  localparam logic [5:0] C_FN_ADD  = 6'h20;
  localparam logic [5:0] C_FN_SUB  = 6'h22;
  localparam logic [5:0] C_FN_AND  = 6'h24;
  localparam logic [5:0] C_FN_OR   = 6'h25;
  localparam logic [5:0] C_FN_NOR  = 6'h27;
  localparam logic [5:0] C_FN_SLT  = 6'h2A;

  // Second ALU operand source
  typedef enum logic [1:0] {
    SRC2_RT    = 2'd0,  // register rt
    SRC2_SIMM  = 2'd1,  // sign-extended immediate
    SRC2_ZIMM  = 2'd2,  // zero-extended immediate
    SRC2_SHAMT = 2'd3   // shift amount field
  } src2_sel_e;

  // One buffered instruction together with its decode result
  typedef struct packed {
    logic [3:0]  ctrl;
    src2_sel_e   src2_sel;
    logic        illegal;
    logic [31:0] instr;
  } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_decode
// Purpose : Purely combinational ALU-control decoder. Maps the opcode and
//           funct fields of a MIPS instruction to the ALU control code, the
//           src2 operand source, and an illegal flag.
// Ports   : opcode_i   [5:0] instr[31:26]
//           funct_i    [5:0] instr[5:0]
//           ctrl_o     [3:0] ALU control code
//           src2_sel_o [1:0] src2 operand select
//           illegal_o        opcode/funct not decodable
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output src2_sel_e  src2_sel_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o     = C_ALU_AND;
    src2_sel_o = SRC2_RT;
    illegal_o  = 1'b0;
    if (opcode_i == C_OP_RTYPE) begin
      unique case (funct_i)
        C_FN_ADD:  ctrl_o = C_ALU_ADD;
        C_FN_SUB:  ctrl_o = C_ALU_SUB;
        C_FN_AND:  ctrl_o = C_ALU_AND;
        C_FN_OR:   ctrl_o = C_ALU_OR;
        C_FN_NOR:  ctrl_o = C_ALU_NOR;
        C_FN_SLT:  ctrl_o = C_ALU_SLT;
        C_FN_MUL:  ctrl_o = C_ALU_MUL;
        C_FN_SRA: begin
          ctrl_o     = C_ALU_SRA;
          src2_sel_o = SRC2_SHAMT;
        end
        C_FN_SRAV: ctrl_o = C_ALU_SRA;  // shift amount comes from rt
        default:   illegal_o = 1'b1;
      endcase
    end else begin
      unique case (opcode_i)
        C_OP_ADDI: begin
          ctrl_o     = C_ALU_ADD;
          src2_sel_o = SRC2_SIMM;
        end
        C_OP_SLTI: begin
          ctrl_o     = C_ALU_SLT;
          src2_sel_o = SRC2_SIMM;
        end
        C_OP_ORI: begin
          ctrl_o     = C_ALU_OR;
          src2_sel_o = SRC2_ZIMM;
        end
        C_OP_LUI: begin
          ctrl_o     = C_ALU_LUI;
          src2_sel_o = SRC2_ZIMM;
        end
        // Branches compare two registers by subtraction
        C_OP_BEQ, C_OP_BNE: ctrl_o = C_ALU_SUB;
        C_OP_SLE:           ctrl_o = C_ALU_SLE;
        // Loads/stores compute base + signed offset
        C_OP_LW, C_OP_SW: begin
          ctrl_o     = C_ALU_ADD;
          src2_sel_o = SRC2_SIMM;
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_issue
// Purpose : ID->EX issue stage. Decodes each accepted instruction into ALU
//           control and src2 select and holds it in a 2-entry skid buffer
//           (output register + skid register) with valid/ready on both sides.
// Ports   : clk_i        rising-edge clock
//           rst_i        asynchronous active-low reset
//           instr_i[31:0], valid_i, ready_o   upstream (ID) handshake
//           flush_i      discard all held entries
//           ctrl_o[3:0], src2_sel_o[1:0], illegal_o, instr_o[31:0],
//           valid_o, ready_i                   downstream (EX) handshake
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_issue
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  output logic [3:0]  ctrl_o,
  output logic [1:0]  src2_sel_o,
  output logic        illegal_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e       r_state;
  logic         r_valid;
  logic         r_ready;
  issue_entry_t r_out;
  issue_entry_t r_skid;

  logic [3:0]   w_dec_ctrl;
  src2_sel_e    w_dec_src2;
  logic         w_dec_illegal;
  issue_entry_t w_new;
  logic         w_accept;
  logic         w_issue;

  alu_ctrl_decode u_decode (
    .opcode_i   (instr_i[31:26]),
    .funct_i    (instr_i[5:0]),
    .ctrl_o     (w_dec_ctrl),
    .src2_sel_o (w_dec_src2),
    .illegal_o  (w_dec_illegal)
  );

  always_comb begin
    w_new.ctrl     = w_dec_ctrl;
    w_new.src2_sel = w_dec_src2;
    w_new.illegal  = w_dec_illegal;
    w_new.instr    = instr_i;
  end

  // Handshakes use the registered valid/ready, so ready_o never depends on
  // ready_i combinationally.
  assign w_accept = valid_i && r_ready;
  assign w_issue  = r_valid && ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle accept or issue
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out   <= w_new;
            r_state <= ST_ONE;
            r_valid <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_issue) begin
            r_out <= w_new;
          end else if (w_accept) begin
            // EX stalled: park the new entry behind the held one
            r_skid  <= w_new;
            r_state <= ST_FULL;
            r_ready <= 1'b0;
          end else if (w_issue) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_issue) begin
            r_out   <= r_skid;
            r_state <= ST_ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign valid_o    = r_valid;
  assign ready_o    = r_ready;
  assign ctrl_o     = r_out.ctrl;
  assign src2_sel_o = r_out.src2_sel;
  assign illegal_o  = r_out.illegal;
  assign instr_o    = r_out.instr;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_ctrl_issue
// Purpose : Self-checking bench for alu_ctrl_issue. A queue-based model of
//           the 2-deep FIFO plus a table decoder gives the expected outputs
//           every cycle; directed cases pin literal values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_issue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [3:0]  ctrl_o;
  logic [1:0]  src2_sel_o;
  logic        illegal_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        ready_i;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] q[$];  // model contents, head = entry on the outputs

  localparam logic [31:0] C_ADD = 32'h00221820;
  localparam logic [31:0] C_SUB = 32'h00221822;
  localparam logic [31:0] C_SLT = 32'h0022182A;

  logic [5:0] fn_list [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h03, 6'h07};
  logic [5:0] op_list [9] = '{6'h08, 6'h0A, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h23, 6'h2B};

  alu_ctrl_issue dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .instr_i    (instr_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .flush_i    (flush_i),
    .ctrl_o     (ctrl_o),
    .src2_sel_o (src2_sel_o),
    .illegal_o  (illegal_o),
    .instr_o    (instr_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  always #5 clk = ~clk;

  // Reference decode: returns {ctrl[3:0], src2[1:0], illegal}
  function automatic logic [6:0] ref_dec(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return {4'd2, 2'd0, 1'b0};
        6'h22: return {4'd6, 2'd0, 1'b0};
        6'h24: return {4'd0, 2'd0, 1'b0};
        6'h25: return {4'd1, 2'd0, 1'b0};
        6'h27: return {4'd12, 2'd0, 1'b0};
        6'h2A: return {4'd7, 2'd0, 1'b0};
        6'h18: return {4'd3, 2'd0, 1'b0};
        6'h03: return {4'd10, 2'd3, 1'b0};
        6'h07: return {4'd10, 2'd0, 1'b0};
        default: return {4'd0, 2'd0, 1'b1};
      endcase
    end
    case (op)
      6'h08, 6'h23, 6'h2B: return {4'd2, 2'd1, 1'b0};
      6'h0A: return {4'd7, 2'd1, 1'b0};
      6'h0D: return {4'd1, 2'd2, 1'b0};
      6'h0F: return {4'd14, 2'd2, 1'b0};
      6'h04, 6'h05: return {4'd6, 2'd0, 1'b0};
      6'h06: return {4'd15, 2'd0, 1'b0};
      default: return {4'd0, 2'd0, 1'b1};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 3);
    if (k == 0) begin
      r[31:26] = 6'h00;
      r[5:0]   = fn_list[$urandom_range(0, 8)];
    end else if (k == 1) begin
      r[31:26] = op_list[$urandom_range(0, 8)];
    end else if (k == 2) begin
      r[31:26] = 6'h00;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [6:0] e;
    chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(q.size() < 2));
    if (q.size() > 0) begin
      e = ref_dec(q[0]);
      chk("ctrl_o", 32'(ctrl_o), 32'(e[6:3]));
      chk("src2_sel_o", 32'(src2_sel_o), 32'(e[2:1]));
      chk("illegal_o", 32'(illegal_o), 32'(e[0]));
      chk("instr_o", instr_o, q[0]);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit acc;
    bit iss;
    if (!rst_i || flush_i) begin
      q.delete();
    end else begin
      acc = valid_i && (q.size() < 2);
      iss = (q.size() > 0) && ready_i;
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(instr_i);
    end
  endtask

  // Called at a negedge: drive inputs, take one edge, check at next negedge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    valid_i = v;
    instr_i = ins;
    ready_i = rdy;
    flush_i = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    instr_i = '0;
    ready_i = 1'b0;
    flush_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst ready_o", 32'(ready_o), 32'd1);
    chk("rst ctrl_o", 32'(ctrl_o), 32'd0);
    chk("rst src2_sel_o", 32'(src2_sel_o), 32'd0);
    chk("rst illegal_o", 32'(illegal_o), 32'd0);
    chk("rst instr_o", instr_o, 32'd0);
    rst_i = 1'b1;

    // Basic decode with EX always ready
    cyc(1'b1, C_ADD, 1'b1, 1'b0);
    chk("add valid", 32'(valid_o), 32'd1);
    chk("add ctrl", 32'(ctrl_o), 32'd2);
    chk("add src2", 32'(src2_sel_o), 32'd0);
    chk("add illegal", 32'(illegal_o), 32'd0);
    cyc(1'b1, 32'h3C011234, 1'b1, 1'b0);
    chk("lui ctrl", 32'(ctrl_o), 32'd14);
    chk("lui src2", 32'(src2_sel_o), 32'd2);
    cyc(1'b1, 32'h00021903, 1'b1, 1'b0);
    chk("sra ctrl", 32'(ctrl_o), 32'd10);
    chk("sra src2", 32'(src2_sel_o), 32'd3);
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0);
    chk("illegal ctrl", 32'(ctrl_o), 32'd0);
    chk("illegal flag", 32'(illegal_o), 32'd1);
    chk("illegal valid", 32'(valid_o), 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain valid", 32'(valid_o), 32'd0);

    // Stall with three back-to-back offers; the third waits upstream
    cyc(1'b1, C_ADD, 1'b0, 1'b0);
    chk("stall1 ctrl", 32'(ctrl_o), 32'd2);
    cyc(1'b1, C_SUB, 1'b0, 1'b0);
    chk("stall2 ready_o", 32'(ready_o), 32'd0);
    cyc(1'b1, C_SLT, 1'b0, 1'b0);
    chk("stall3 ready_o", 32'(ready_o), 32'd0);
    chk("stall3 ctrl", 32'(ctrl_o), 32'd2);
    cyc(1'b1, C_SLT, 1'b1, 1'b0);
    chk("order 2nd ctrl", 32'(ctrl_o), 32'd6);
    cyc(1'b1, C_SLT, 1'b1, 1'b0);
    chk("order 3rd ctrl", 32'(ctrl_o), 32'd7);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("order drained", 32'(valid_o), 32'd0);

    // Flush from FULL together with valid_i
    cyc(1'b1, C_ADD, 1'b0, 1'b0);
    cyc(1'b1, C_SUB, 1'b0, 1'b0);
    cyc(1'b1, C_SLT, 1'b0, 1'b1);
    chk("flush full valid", 32'(valid_o), 32'd0);
    chk("flush full ready", 32'(ready_o), 32'd1);
    // Flush from ONE drops the same-cycle accept
    cyc(1'b1, C_ADD, 1'b0, 1'b0);
    cyc(1'b1, C_SLT, 1'b0, 1'b1);
    chk("flush one valid", 32'(valid_o), 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("flush no reissue", 32'(valid_o), 32'd0);

    // Asynchronous reset between clock edges
    cyc(1'b1, C_ADD, 1'b0, 1'b0);
    cyc(1'b1, C_SUB, 1'b0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    chk("arst valid", 32'(valid_o), 32'd0);
    chk("arst ctrl", 32'(ctrl_o), 32'd0);
    chk("arst ready", 32'(ready_o), 32'd1);
    q.delete();
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_model();
    rst_i = 1'b1;
    cyc(1'b1, C_SUB, 1'b1, 1'b0);
    chk("post-rst ctrl", 32'(ctrl_o), 32'd6);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_instr(),
          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
